// File: rtl/lock_ctrl_pkg.sv
// Shared types and width helpers for the lock attempt controller.
package lock_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SEND,
        S_CHECK,
        S_RESP,
        S_LOCKOUT
    } state_t;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int ctr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int fail_w(input int max_fail);
        return $clog2(max_fail + 1);
    endfunction

    function automatic int bit_w(input int key_len);
        return ctr_w(key_len);
    endfunction

    function automatic int lockout_w(input int lockout_cycles);
        return ctr_w(lockout_cycles);
    endfunction

endpackage

// File: rtl/lock_key_serializer.sv
// Holds the attempt word and emits it MSB-first, one bit per shift.
module lock_key_serializer
    import lock_ctrl_pkg::*;
#(
    parameter int KEY_LEN = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [KEY_LEN-1:0] key,
    input  logic               shift,
    output logic               bit_cur,
    output logic               last_bit
);

    localparam int BW = bit_w(KEY_LEN);

    logic [KEY_LEN-1:0] sreg;
    logic [BW-1:0]      bcnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sreg <= '0;
            bcnt <= '0;
        end else if (load) begin
            sreg <= key;
            bcnt <= '0;
        end else if (shift) begin
            sreg <= sreg << 1;
            bcnt <= bcnt + BW'(1);
        end
    end

    assign bit_cur  = sreg[KEY_LEN-1];
    assign last_bit = (bcnt == BW'(KEY_LEN - 1));

endmodule

// File: rtl/lock_attempt_ctrl.sv
// Sequences key attempts into the serial lock, reports pass/fail and
// enforces a timed lockout after MAX_FAIL consecutive failures.
module lock_attempt_ctrl
    import lock_ctrl_pkg::*;
#(
    parameter int KEY_LEN        = 5,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          att_valid,
    output logic                          att_ready,
    input  logic [KEY_LEN-1:0]            att_key,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic                          resp_pass,
    output logic                          resp_lockout,
    output logic                          locked_out,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
    output logic                          lock_rst,
    output logic                          lock_inp0,
    output logic                          lock_inp1,
    input  logic                          lock_unlock
);

    localparam int FW  = fail_w(MAX_FAIL);
    localparam int LCW = lockout_w(LOCKOUT_CYCLES);

    state_t         state;
    logic [LCW-1:0] lo_cnt;
    logic           bit_cur;
    logic           last_bit;

    lock_key_serializer #(.KEY_LEN(KEY_LEN)) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (state == S_IDLE && att_valid),
        .key      (att_key),
        .shift    (state == S_SEND),
        .bit_cur  (bit_cur),
        .last_bit (last_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            fail_cnt     <= '0;
            resp_pass    <= 1'b0;
            resp_lockout <= 1'b0;
            locked_out   <= 1'b0;
            lo_cnt       <= '0;
        end else begin
            case (state)
                S_IDLE:  if (att_valid) state <= S_CLR;
                S_CLR:   state <= S_SEND;
                S_SEND:  if (last_bit) state <= S_CHECK;
                S_CHECK: begin
                    resp_pass    <= lock_unlock;
                    resp_lockout <= 1'b0;
                    if (lock_unlock) begin
                        fail_cnt <= '0;
                    end else begin
                        // Saturate defensively; lockout normally clears it first.
                        if (fail_cnt != FW'(MAX_FAIL))
                            fail_cnt <= fail_cnt + FW'(1);
                        resp_lockout <= (fail_cnt == FW'(MAX_FAIL - 1));
                    end
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        if (resp_lockout) begin
                            state      <= S_LOCKOUT;
                            locked_out <= 1'b1;
                            lo_cnt     <= LCW'(LOCKOUT_CYCLES - 1);
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (lo_cnt == '0) begin
                        state      <= S_IDLE;
                        locked_out <= 1'b0;
                        fail_cnt   <= '0;
                    end else begin
                        lo_cnt <= lo_cnt - LCW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign att_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign lock_inp1  = (state == S_SEND) &&  bit_cur;
    assign lock_inp0  = (state == S_SEND) && !bit_cur;
    // Combinational so the lock datapath resets in the same edge as the controller.
    assign lock_rst   = (state == S_CLR) || (state == S_LOCKOUT) || !rst;

endmodule

// File: tb/tb_lock_attempt_ctrl.sv
// Randomised bench: transaction-level model of attempts, fail count and lockout.
module tb_lock_attempt_ctrl;

    localparam int KEY_LEN        = 5;
    localparam int MAX_FAIL       = 3;
    localparam int LOCKOUT_CYCLES = 16;
    localparam int FW             = $clog2(MAX_FAIL + 1);
    localparam logic [KEY_LEN-1:0] SECRET = 5'b01011;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               att_valid = 1'b0;
    logic               att_ready;
    logic [KEY_LEN-1:0] att_key = '0;
    logic               resp_valid;
    logic               resp_ready = 1'b0;
    logic               resp_pass;
    logic               resp_lockout;
    logic               locked_out;
    logic [FW-1:0]      fail_cnt;
    logic               lock_rst;
    logic               lock_inp0;
    logic               lock_inp1;
    logic               lock_unlock;

    int n_vec = 0;
    int n_err = 0;
    int m_fail = 0;
    int last_wait = 0;

    always #5 clk = ~clk;

    lock_attempt_ctrl #(
        .KEY_LEN(KEY_LEN), .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .att_valid(att_valid), .att_ready(att_ready), .att_key(att_key),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_pass(resp_pass), .resp_lockout(resp_lockout),
        .locked_out(locked_out), .fail_cnt(fail_cnt),
        .lock_rst(lock_rst), .lock_inp0(lock_inp0), .lock_inp1(lock_inp1),
        .lock_unlock(lock_unlock)
    );

    // Behavioural serial lock: unlocks once the last KEY_LEN pulses spell SECRET.
    logic [KEY_LEN-1:0] lk_hist = '0;
    int                 lk_n = 0;
    always @(posedge clk) begin
        if (lock_rst) begin
            lk_hist <= '0;
            lk_n    <= 0;
        end else if (lock_inp0 || lock_inp1) begin
            lk_hist <= {lk_hist[KEY_LEN-2:0], lock_inp1};
            if (lk_n < KEY_LEN) lk_n <= lk_n + 1;
        end
    end
    assign lock_unlock = (lk_n >= KEY_LEN) && (lk_hist == SECRET);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_attempt(input logic [KEY_LEN-1:0] key, input int rdy_delay,
                               input bit noise, input bit hold);
        logic exp_pass, exp_lo, b;
        logic p0, l0;
        int w;
        att_key = key;
        att_valid = 1'b1;
        w = 0;
        while (!att_ready && w < 200) begin
            step();
            w++;
        end
        chk("accept_timeout", (w < 200), 1);
        last_wait = w;
        step();
        att_valid = 1'b0;
        chk("clr_lock_rst", lock_rst, 1);
        chk("clr_ready", att_ready, 0);
        for (int i = 0; i < KEY_LEN; i++) begin
            step();
            b = key[KEY_LEN-1-i];
            chk("send_inp1", lock_inp1, b);
            chk("send_inp0", lock_inp0, !b);
        end
        step();
        chk("check_no_valid", resp_valid, 0);
        step();
        exp_pass = (key == SECRET);
        exp_lo = !exp_pass && (m_fail + 1 == MAX_FAIL);
        if (exp_pass) m_fail = 0;
        else if (m_fail < MAX_FAIL) m_fail++;
        chk("resp_valid", resp_valid, 1);
        chk("resp_pass", resp_pass, exp_pass);
        chk("resp_lockout", resp_lockout, exp_lo);
        chk("fail_cnt", fail_cnt, m_fail);
        chk("resp_att_ready", att_ready, 0);
        p0 = resp_pass;
        l0 = resp_lockout;
        for (int d = 0; d < rdy_delay; d++) begin
            if (noise) begin
                att_valid = 1'($urandom_range(0, 1));
                att_key = KEY_LEN'($urandom);
            end
            step();
            chk("hold_valid", resp_valid, 1);
            chk("hold_pass", resp_pass, p0);
            chk("hold_lockout", resp_lockout, l0);
        end
        att_valid = 1'b0;
        att_key = key;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        if (exp_lo) begin
            if (hold) begin
                att_valid = 1'b1;
                att_key = SECRET;
            end
            for (int k = 0; k < LOCKOUT_CYCLES; k++) begin
                chk("lo_locked", locked_out, 1);
                chk("lo_ready", att_ready, 0);
                chk("lo_lock_rst", lock_rst, 1);
                step();
            end
            m_fail = 0;
            chk("lo_exit_ready", att_ready, 1);
            chk("lo_exit_locked", locked_out, 0);
            chk("lo_exit_fail", fail_cnt, 0);
        end else begin
            chk("post_ready", att_ready, 1);
            chk("post_valid", resp_valid, 0);
            chk("post_locked", locked_out, 0);
        end
    endtask

    initial begin
        rst = 1'b0;
        step();
        step();
        chk("rst_fail", fail_cnt, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_pass", resp_pass, 0);
        chk("rst_lo", resp_lockout, 0);
        chk("rst_locked", locked_out, 0);
        chk("rst_inp", {lock_inp0, lock_inp1}, 0);
        chk("rst_lock_rst", lock_rst, 1);
        rst = 1'b1;
        step();
        chk("rel_ready", att_ready, 1);
        chk("rel_lock_rst", lock_rst, 0);

        // Correct key, then three failures into lockout.
        run_attempt(SECRET, 0, 0, 0);
        run_attempt('0, 1, 0, 0);
        run_attempt('0, 0, 0, 0);
        run_attempt('0, 2, 0, 0);

        // Two failures, pass clears the count, next failure no lockout.
        run_attempt(5'b11111, 0, 0, 0);
        run_attempt(5'b00011, 0, 0, 0);
        run_attempt(SECRET, 0, 0, 0);
        run_attempt(5'b10101, 0, 0, 0);

        // Stalled response with att_valid noise.
        run_attempt(SECRET, 10, 1, 0);
        step();
        chk("noise_no_extra", resp_valid, 0);

        // Reset mid-SEND (bit 2 on the wire).
        att_key = SECRET;
        att_valid = 1'b1;
        step();
        att_valid = 1'b0;
        step();
        step();
        step();
        chk("pre_rst_inp1", lock_inp1, SECRET[KEY_LEN-3]);
        rst = 1'b0;
        #1;
        chk("midrst_lock_rst_comb", lock_rst, 1);
        step();
        chk("midrst_valid", resp_valid, 0);
        chk("midrst_inp", {lock_inp0, lock_inp1}, 0);
        chk("midrst_fail", fail_cnt, 0);
        chk("midrst_lock_rst", lock_rst, 1);
        rst = 1'b1;
        m_fail = 0;
        step();
        chk("midrst_ready", att_ready, 1);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("midrst_no_resp", resp_valid, 0);
        end
        run_attempt(SECRET, 0, 0, 0);

        // att_valid held through lockout: accepted on first IDLE cycle.
        run_attempt('0, 0, 0, 0);
        run_attempt('0, 0, 0, 0);
        run_attempt('0, 0, 0, 1);
        run_attempt(SECRET, 0, 0, 0);
        chk("hold_accept_wait", last_wait, 0);

        // Randomised traffic.
        for (int t = 0; t < 40; t++) begin
            logic [KEY_LEN-1:0] k;
            k = ($urandom_range(0, 2) == 0) ? SECRET : KEY_LEN'($urandom);
            run_attempt(k, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
